// File: rtl/key_debounce_pulse.sv
// Key debouncer: turns a raw, bouncing button pin into a clean registered level plus press/release pulses.
// Ports: clk, rd (sync reset, active-high), key_in (raw pin) -> key_level, key_press, key_release.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to get key_press auto-repeat while the key is held.
module key_debounce_pulse #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int CNT_W        = 20,
  parameter int ACTIVE_LOW   = 1,
  parameter int HOLD_CYC     = 16,
  parameter int REPEAT_CYC   = 8
) (
  input  logic clk,
  input  logic rd,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  // Pin level that means "released".
  localparam logic REL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  if (DEBOUNCE_CYC < 2) begin : g_bad_db
    $error("DEBOUNCE_CYC must be >= 2");
  end
  if (HOLD_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_rep
    $error("HOLD_CYC and REPEAT_CYC must be >= 1");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             s1, s2, r1, r2;
  logic             p, raw_p, armed;
  logic             acc_press, acc_rel, rep_hit;
  logic             level_n, press_n, release_n;

  // Forced chain feeds the FSM; it reads "released" while rd is high.
  always_ff @(posedge clk) begin
    if (rd) begin
      s1 <= REL;
      s2 <= REL;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  // Free-running chain sees the true pin, even during reset.
  always_ff @(posedge clk) begin
    r1 <= key_in;
    r2 <= r1;
  end

  assign p     = s2 ^ REL;
  assign raw_p = r2 ^ REL;

  // A key held through reset must be released once before a
  // new press can be accepted.
  always_ff @(posedge clk) begin
    if (rd)          armed <= ~raw_p;
    else if (!raw_p) armed <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rd) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    acc_press = 1'b0;
    acc_rel   = 1'b0;
    unique case (state)
      IDLE: begin
        if (p && armed) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n   = PRESSED;
          cnt_n     = '0;
          acc_press = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!p) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          acc_rel = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

  logic [CNT_W-1:0] rcnt;
  logic             rep_done;
  logic             in_hold;

  // Only counts while staying in PRESSED; any exit restarts the hold delay.
  assign in_hold = (state == PRESSED) && p;
  assign rep_hit = in_hold &&
                   (rcnt == (rep_done ? REP_LAST : HOLD_LAST));

  always_ff @(posedge clk) begin
    if (rd || !in_hold) begin
      rcnt     <= '0;
      rep_done <= 1'b0;
    end else if (rep_hit) begin
      rcnt     <= '0;
      rep_done <= 1'b1;
    end else begin
      rcnt <= rcnt + CNT_W'(1);
    end
  end
`else
  assign rep_hit = 1'b0;
`endif

  always_comb begin
    level_n   = (state_n == PRESSED) || (state_n == RELEASE_WAIT);
    press_n   = acc_press | rep_hit;
    release_n = acc_rel;
  end

  always_ff @(posedge clk) begin
    if (rd) begin
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_level   <= level_n;
      key_press   <= press_n;
      key_release <= release_n;
    end
  end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Testbench for key_debounce_pulse: directed scenarios plus random key traffic
// checked every cycle against a run-length model of the debouncer.
module tb_key_debounce_pulse;

  localparam int D    = 4;
  localparam int AL   = 1;
  localparam int HOLD = 16;
  localparam int REP  = 8;

  logic clk = 1'b0;
  logic rd = 1'b1;
  logic key_in = 1'b1;
  logic key_level, key_press, key_release;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  key_debounce_pulse #(
    .DEBOUNCE_CYC(D),
    .CNT_W(20),
    .ACTIVE_LOW(AL),
    .HOLD_CYC(HOLD),
    .REPEAT_CYC(REP)
  ) dut (
    .clk(clk),
    .rd(rd),
    .key_in(key_in),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release)
  );

  // Model state: accepted level, length of the current run of samples
  // that disagree with it, and cycles held since (re)entering the hold.
  logic m_level = 1'b0, m_press = 1'b0, m_rel = 1'b0;
  logic m_armed = 1'b0;
  logic f0 = 1'b0, f1 = 1'b0;
  logic h0 = 1'b0, h1 = 1'b0;
  int   m_run = 0;
  int   m_k = -1;

  function automatic logic pp(input logic k);
    return (AL != 0) ? ~k : k;
  endfunction

  task automatic model_step();
    logic samp, raw_old;
    samp    = f1;
    raw_old = pp(h1);
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (rd) begin
      m_level = 1'b0;
      m_run   = 0;
      m_k     = -1;
      m_armed = ~raw_old;
      f0      = 1'b0;
      f1      = 1'b0;
    end else begin
      if (samp == m_level) m_run = 0;
      else if (m_level || m_armed) m_run++;
      if (m_run == D + 1) begin
        m_level = ~m_level;
        m_run   = 0;
        if (m_level) begin
          m_press = 1'b1;
          m_k     = 0;
        end else begin
          m_rel = 1'b1;
          m_k   = -1;
        end
      end else if (m_level) begin
        if (!samp) m_k = -1;
        else if (m_k < 0) m_k = 0;
        else begin
          m_k++;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
          if (m_k == HOLD ||
              (m_k > HOLD && (m_k - HOLD) % REP == 0))
            m_press = 1'b1;
`endif
        end
      end
      if (!raw_old) m_armed = 1'b1;
      f1 = f0;
      f0 = pp(key_in);
    end
    h1 = h0;
    h0 = key_in;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    cyc_no++;
  end

  task automatic check(input string nm, input logic act,
                       input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %b want %b",
               nm, cyc_no, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("m_level", key_level, m_level);
      check("m_press", key_press, m_press);
      check("m_release", key_release, m_rel);
      check("m_excl", key_press & key_release, 1'b0);
    end
  end

  task automatic cyc(input logic k, input logic r);
    key_in = k;
    rd     = r;
    @(negedge clk);
    #1;
  endtask

  int npress;
  int first;
  int offs[$];
  int hold_left;
  logic lvl;
  logic rr;

  initial begin
    rd     = 1'b1;
    key_in = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_level", key_level, 1'b0);
    check("rst_press", key_press, 1'b0);

    // Clean press: visible only after edge D+3.
    for (int e = 1; e <= 8; e++) begin
      cyc(1'b0, 1'b0);
      check("t1_press", key_press, e == D + 3);
      check("t1_level", key_level, e >= D + 3);
    end
    repeat (3) cyc(1'b0, 1'b0);

    // Clean release.
    for (int e = 1; e <= 8; e++) begin
      cyc(1'b1, 1'b0);
      check("t3_release", key_release, e == D + 3);
      check("t3_level", key_level, e < D + 3);
      check("t3_press", key_press, 1'b0);
    end
    repeat (3) cyc(1'b1, 1'b0);

    // Bounce shorter than the debounce window.
    for (int i = 0; i < 17; i++) begin
      cyc((i < 3) ? 1'b0 : (i < 5) ? 1'b1 :
          (i < 7) ? 1'b0 : 1'b1, 1'b0);
      check("t2_level", key_level, 1'b0);
      check("t2_press", key_press, 1'b0);
    end

    repeat (10) cyc(1'b0, 1'b0);
    check("t4_pre_level", key_level, 1'b1);

    // Release glitch while pressed.
    for (int i = 0; i < 12; i++) begin
      cyc((i < 2) ? 1'b1 : 1'b0, 1'b0);
      check("t4_level", key_level, 1'b1);
      check("t4_press", key_press, 1'b0);
      check("t4_release", key_release, 1'b0);
    end

    // Reset mid-press with the key still held.
    cyc(1'b0, 1'b1);
    check("t5_level", key_level, 1'b0);
    check("t5_release", key_release, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0);
      check("t5_held_press", key_press, 1'b0);
      check("t5_held_level", key_level, 1'b0);
    end
    repeat (3) cyc(1'b1, 1'b0);
    npress = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0);
      if (key_press) npress++;
    end
    check("t5_repress", npress == 1, 1'b1);

    // Long hold: first press then 40 more held cycles.
    repeat (10) cyc(1'b1, 1'b0);
    first = -1;
    offs.delete();
    for (int j = 1; j <= D + 3 + 40; j++) begin
      cyc(1'b0, 1'b0);
      if (key_press) begin
        if (first < 0) first = j;
        offs.push_back(j - first);
      end
    end
    check("t6_first", first == D + 3, 1'b1);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    check("t6_count", offs.size() == 5, 1'b1);
    if (offs.size() >= 3) begin
      check("t6_rep1", offs[1] == 16, 1'b1);
      check("t6_rep2", offs[2] == 24, 1'b1);
    end else begin
      check("t6_reps_present", 1'b0, 1'b1);
    end
`else
    check("t6_count", offs.size() == 1, 1'b1);
`endif
    repeat (10) cyc(1'b1, 1'b0);

    // Random bursty traffic with occasional resets.
    hold_left = 0;
    lvl = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        lvl = 1'($urandom_range(0, 1));
        hold_left = int'($urandom_range(1, 9));
      end
      hold_left--;
      rr = ($urandom_range(0, 199) == 0);
      cyc(lvl, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
